// File: rtl/dmem_pkg.sv
// Shared constants and types for the RV32I data memory controller.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the load/store stage (master) and dmem_ctrl (slave).
interface dmem_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering, load extension and access legality for one RV32I access.
// Misaligned accesses are flagged only when DMEM_MISALIGN_TRAP_EN is defined.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic            we_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [31:0]     wdata_i,
  input  logic [31:0]     rdword_i,
  output logic [BE_W-1:0] be_o,
  output logic [31:0]     wdata_o,
  output logic [31:0]     rdata_o,
  output logic            misalign_o,
  output logic            illegal_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store lanes: replicated data lets the byte enables pick the right lane.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0000_0000;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
      end
      2'b10: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
      default: begin
        be_o    = 4'b0000;
        wdata_o = 32'h0000_0000;
      end
    endcase
  end

  // Load lane selection and sign/zero extension.
  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_s = rdword_i[7:0];
      2'd1:    byte_s = rdword_i[15:8];
      2'd2:    byte_s = rdword_i[23:16];
      default: byte_s = rdword_i[31:24];
    endcase
    if (addr_lo_i[1]) begin
      half_s = rdword_i[31:16];
    end else begin
      half_s = rdword_i[15:0];
    end
    case (funct3_i)
      F3_B:    rdata_o = {{24{byte_s[7]}}, byte_s};
      F3_BU:   rdata_o = {24'h000000, byte_s};
      F3_H:    rdata_o = {{16{half_s[15]}}, half_s};
      F3_HU:   rdata_o = {16'h0000, half_s};
      F3_W:    rdata_o = rdword_i;
      default: rdata_o = 32'h0000_0000;
    endcase
  end

  // Stores only have B/H/W encodings; loads add BU/HU.
  always_comb begin
    if (we_i) begin
      illegal_o = funct3_i[2] | (funct3_i == 3'b011);
    end else begin
      illegal_o = (funct3_i == 3'b011) | (funct3_i == 3'b110) | (funct3_i == 3'b111);
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  // Halfwords need bit 0 clear, words need both low bits clear.
  always_comb begin
    case (funct3_i[1:0])
      2'b01:   misalign_o = addr_lo_i[0];
      2'b10:   misalign_o = |addr_lo_i;
      default: misalign_o = 1'b0;
    endcase
  end
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// RV32I data memory: valid/ready request and response, WAIT_STATES extra cycles,
// byte/half/word access. Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int         AW      = $clog2(DEPTH);
  localparam bit         ZERO_WS = (WAIT_STATES == 0);
  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        busy_q;

  logic [31:0] mem_q [DEPTH];

  logic            cur_we_s;
  logic [2:0]      cur_funct3_s;
  logic [31:0]     cur_addr_s;
  logic [31:0]     cur_wdata_s;
  logic [AW-1:0]   idx_s;
  logic [31:0]     rdword_s;
  logic [BE_W-1:0] be_s;
  logic [31:0]     wdata_al_s;
  logic [31:0]     ext_s;
  logic            misalign_s;
  logic            illegal_s;
  logic            oor_s;
  logic            err_s;
  logic            commit_s;
  logic            wr_en_s;
  logic [31:0]     rsp_rdata_d;

  // With zero wait states the commit edge is the accept edge, so use the live bus.
  assign cur_we_s     = (state_q == ST_IDLE) ? bus.req_we     : we_q;
  assign cur_funct3_s = (state_q == ST_IDLE) ? bus.req_funct3 : funct3_q;
  assign cur_addr_s   = (state_q == ST_IDLE) ? bus.req_addr   : addr_q;
  assign cur_wdata_s  = (state_q == ST_IDLE) ? bus.req_wdata  : wdata_q;

  assign idx_s    = cur_addr_s[AW+1:2];
  assign oor_s    = |(cur_addr_s >> (AW + 2));
  assign rdword_s = mem_q[idx_s];

  dmem_lane_align u_align (
    .we_i      (cur_we_s),
    .funct3_i  (cur_funct3_s),
    .addr_lo_i (cur_addr_s[1:0]),
    .wdata_i   (cur_wdata_s),
    .rdword_i  (rdword_s),
    .be_o      (be_s),
    .wdata_o   (wdata_al_s),
    .rdata_o   (ext_s),
    .misalign_o(misalign_s),
    .illegal_o (illegal_s)
  );

  assign err_s       = oor_s | illegal_s | misalign_s;
  assign commit_s    = ((state_q == ST_IDLE) && bus.req_valid && ZERO_WS) ||
                       ((state_q == ST_WAIT) && (cnt_q == 4'd0));
  assign wr_en_s     = commit_s && cur_we_s && !err_s && !rst;
  assign rsp_rdata_d = (cur_we_s || err_s) ? 32'h0000_0000 : ext_s;

  // Byte-enabled write port; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_s[b]) begin
          mem_q[idx_s][8*b +: 8] <= wdata_al_s[8*b +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake outputs and response register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      rdata_q     <= 32'h0000_0000;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            funct3_q    <= bus.req_funct3;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (ZERO_WS) begin
              state_q     <= ST_RESP;
              rdata_q     <= rsp_rdata_d;
              err_q       <= err_s;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= WS_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= ST_RESP;
            rdata_q     <= rsp_rdata_d;
            err_q       <= err_s;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= 4'd0;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = busy_q;

endmodule
